// File: rtl/core_boot_loader.sv
// Boot sequencer: streams a length-prefixed, XOR-checked program image into
// instruction memory while the core is held in reset, then releases the core.
module core_boot_loader #(
  parameter int unsigned IMEM_DEPTH     = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  output logic                          rx_ready,
  output logic                          imem_we,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  output logic [31:0]                   imem_wdata,
  output logic                          core_reset,
  output logic                          boot_done,
  output logic                          boot_error,
  output logic [$clog2(IMEM_DEPTH):0]   words_loaded
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [31:0]   DEPTH32  = 32'(IMEM_DEPTH);
  localparam logic [AW:0]   ONE_W    = 1;
  localparam logic [TW-1:0] ONE_T    = 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_LOAD_LEN,
    S_LOAD_DATA,
    S_LOAD_SUM,
    S_RUN,
    S_ERROR
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    byte_idx;
  logic [23:0]   asm_q;      // first three bytes of the current length/word
  logic [AW:0]   n_words;
  logic [7:0]    xsum_q;
  logic [TW-1:0] tmo_q;

  logic          accept;
  logic          tmo_active;
  logic          timeout_hit;
  logic          last_word;
  logic [31:0]   len_full;
  logic [AW:0]   words_nx;

  assign accept     = rx_valid && rx_ready;
  assign len_full   = {rx_data, asm_q};
  assign words_nx   = words_loaded + ONE_W;
  assign last_word  = (words_nx == n_words);
  assign tmo_active = ((state == S_LOAD_LEN) && (byte_idx != 2'd0)) ||
                      (state == S_LOAD_DATA) || (state == S_LOAD_SUM);
  // An accepted byte in the expiry cycle wins over the timeout.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && tmo_active && !accept &&
                       (tmo_q == TMO_LAST);

  // NOTE: state_nx gets its default first so no path through the block can infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_LOAD_LEN: begin
        if (accept && (byte_idx == 2'd3)) begin
          state_nx = ((len_full == 32'd0) || (len_full > DEPTH32)) ? S_ERROR : S_LOAD_DATA;
        end
      end
      S_LOAD_DATA: begin
        if (accept && (byte_idx == 2'd3) && last_word) state_nx = S_LOAD_SUM;
      end
      S_LOAD_SUM: begin
        if (accept) state_nx = (rx_data == xsum_q) ? S_RUN : S_ERROR;
      end
      default: state_nx = state;
    endcase
    if (timeout_hit) state_nx = S_ERROR;
  end

  // Status outputs are registered from the next state so they change on the same edge as state.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_LOAD_LEN;
      rx_ready   <= 1'b1;
      core_reset <= 1'b1;
      boot_done  <= 1'b0;
      boot_error <= 1'b0;
    end else begin
      state      <= state_nx;
      rx_ready   <= (state_nx == S_LOAD_LEN) || (state_nx == S_LOAD_DATA) ||
                    (state_nx == S_LOAD_SUM);
      core_reset <= (state_nx != S_RUN);
      boot_done  <= (state_nx == S_RUN);
      boot_error <= (state_nx == S_ERROR);
    end
  end

  // Instruction memory itself is external and is deliberately left untouched by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx     <= 2'd0;
      asm_q        <= 24'd0;
      n_words      <= '0;
      xsum_q       <= 8'd0;
      tmo_q        <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'd0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      if (accept) begin
        byte_idx <= byte_idx + 2'd1;
        asm_q    <= {rx_data, asm_q[23:8]};
        tmo_q    <= '0;
        if ((state == S_LOAD_LEN) && (byte_idx == 2'd3)) begin
          n_words <= len_full[AW:0];
        end
        if (state == S_LOAD_DATA) begin
          xsum_q <= xsum_q ^ rx_data;
          if (byte_idx == 2'd3) begin
            imem_we      <= 1'b1;
            imem_addr    <= words_loaded[AW-1:0];
            imem_wdata   <= len_full;
            words_loaded <= words_nx;
          end
        end
      end else if (tmo_active && !timeout_hit && (TIMEOUT_CYCLES != 0)) begin
        tmo_q <= tmo_q + ONE_T;
      end
    end
  end

endmodule

// File: tb/tb_core_boot_loader.sv
// Self-checking bench for core_boot_loader: table-driven loads, hand-timed
// sequences, and randomized loads checked against an image-level model.
module tb_core_boot_loader;

  localparam int DEPTH = 16;
  localparam int TMO   = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_reset;
  logic          boot_done;
  logic          boot_error;
  logic [AW:0]   words_loaded;

  core_boot_loader #(.IMEM_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_reset(core_reset), .boot_done(boot_done),
    .boot_error(boot_error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Captured memory writes; cleared whenever reset is seen.
  logic [31:0] mon_mem [DEPTH];
  int          pulses;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      pulses = 0;
      for (int a = 0; a < DEPTH; a++) mon_mem[a] = 'x;
    end else if (imem_we === 1'b1) begin
      mon_mem[imem_addr] = imem_wdata;
      pulses++;
    end
  end

  logic [7:0]  img [$];
  int          gap [$];
  logic [31:0] exp_mem [DEPTH];
  bit          m_done, m_err;
  int          m_words;

  typedef struct {
    logic [31:0] len;
    int          nw;
    bit          bad;
    int          stall_at;
    int          stall_len;
    bit          exp_done;
    bit          exp_err;
    int          exp_words;
  } vec_t;
  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    if (rx_ready) begin
      rx_valid = 1'b1;
      rx_data  = b;
    end else begin
      rx_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic play(input int upto);
    for (int i = 0; i < upto; i++) begin
      idle(gap[i]);
      send(img[i]);
    end
    idle(1);
  endtask

  task automatic build_image(input logic [31:0] len, input int nw, input bit bad);
    logic [7:0]  x;
    logic [31:0] w;
    img.delete();
    gap.delete();
    x = 8'h00;
    for (int k = 0; k < 4; k++) img.push_back(len[8*k +: 8]);
    for (int j = 0; j < nw; j++) begin
      w = $urandom;
      for (int k = 0; k < 4; k++) begin
        img.push_back(w[8*k +: 8]);
        x ^= w[8*k +: 8];
      end
    end
    img.push_back(bad ? (x ^ 8'h01) : x);
    for (int i = 0; i < img.size(); i++) gap.push_back(0);
  endtask

  // Walks the image byte by byte: length, words, checksum, and idle gaps.
  task automatic run_model();
    logic [31:0] n, w;
    logic [7:0]  x;
    m_done = 1'b0; m_err = 1'b0; m_words = 0;
    n = 32'd0; w = 32'd0; x = 8'h00;
    for (int i = 0; i < img.size(); i++) begin
      if (i > 0 && gap[i] >= TMO) begin m_err = 1'b1; break; end
      if (i < 4) begin
        n[8*i +: 8] = img[i];
        if (i == 3 && (n == 32'd0 || n > DEPTH)) begin m_err = 1'b1; break; end
      end else if (i < 4 + 4 * int'(n)) begin
        x ^= img[i];
        w[8*((i-4)%4) +: 8] = img[i];
        if ((i - 4) % 4 == 3) begin
          exp_mem[(i-4)/4] = w;
          m_words++;
        end
      end else begin
        if (img[i] == x) m_done = 1'b1;
        else m_err = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_vs_model(input string tag);
    run_model();
    check({tag, " boot_done"},    boot_done,    m_done);
    check({tag, " boot_error"},   boot_error,   m_err);
    check({tag, " core_reset"},   core_reset,   !m_done);
    check({tag, " rx_ready"},     rx_ready,     !(m_done || m_err));
    check({tag, " words_loaded"}, words_loaded, m_words);
    check({tag, " write pulses"}, pulses,       m_words);
    for (int a = 0; a < m_words; a++)
      check($sformatf("%s mem[%0d]", tag, a), mon_mem[a], exp_mem[a]);
  endtask

  initial begin
    logic [7:0] nom [13];
    int n;
    bit bad;

    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    #12;
    check("reset rx_ready",     rx_ready,     1);
    check("reset core_reset",   core_reset,   1);
    check("reset imem_we",      imem_we,      0);
    check("reset imem_addr",    imem_addr,    0);
    check("reset imem_wdata",   imem_wdata,   0);
    check("reset boot_done",    boot_done,    0);
    check("reset boot_error",   boot_error,   0);
    check("reset words_loaded", words_loaded, 0);

    // Nominal N=2 load with cycle-exact write and release timing.
    nom = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
            8'h6F, 8'h00, 8'h00, 8'h00, 8'h69};
    do_reset();
    for (int i = 0; i < 8; i++) send(nom[i]);
    idle(1);
    check("nom w0 imem_we",   imem_we,      1);
    check("nom w0 addr",      imem_addr,    0);
    check("nom w0 wdata",     imem_wdata,   32'h0010_0513);
    check("nom w0 words",     words_loaded, 1);
    for (int i = 8; i < 12; i++) send(nom[i]);
    idle(1);
    check("nom w1 imem_we",   imem_we,      1);
    check("nom w1 addr",      imem_addr,    1);
    check("nom w1 wdata",     imem_wdata,   32'h0000_006F);
    idle(1);
    check("nom hold imem_we", imem_we,      0);
    check("nom hold addr",    imem_addr,    1);
    check("nom hold wdata",   imem_wdata,   32'h0000_006F);
    send(nom[12]);
    check("nom pre core_reset", core_reset, 1);
    check("nom pre boot_done",  boot_done,  0);
    idle(1);
    check("nom core_reset",   core_reset,   0);
    check("nom boot_done",    boot_done,    1);
    check("nom boot_error",   boot_error,   0);
    check("nom rx_ready",     rx_ready,     0);
    check("nom words",        words_loaded, 2);
    check("nom pulses",       pulses,       2);
    check("nom mem0",         mon_mem[0],   32'h0010_0513);
    check("nom mem1",         mon_mem[1],   32'h0000_006F);

    // Table of image shapes: lengths, checksums, stalls at boundaries.
    tbl[0]  = '{32'd2,  2,  1'b0, 0,  0,   1'b1, 1'b0, 2};
    tbl[1]  = '{32'd2,  2,  1'b1, 0,  0,   1'b0, 1'b1, 2};
    tbl[2]  = '{32'd0,  0,  1'b0, 0,  0,   1'b0, 1'b1, 0};
    tbl[3]  = '{32'd17, 0,  1'b0, 0,  0,   1'b0, 1'b1, 0};
    tbl[4]  = '{32'd3,  3,  1'b0, 5,  16,  1'b0, 1'b1, 0};
    tbl[5]  = '{32'd3,  3,  1'b0, 5,  15,  1'b1, 1'b0, 3};
    tbl[6]  = '{32'd16, 16, 1'b0, 0,  0,   1'b1, 1'b0, 16};
    tbl[7]  = '{32'd1,  1,  1'b0, 1,  16,  1'b0, 1'b1, 0};
    tbl[8]  = '{32'd2,  2,  1'b0, 12, 16,  1'b0, 1'b1, 2};
    tbl[9]  = '{32'd2,  2,  1'b0, 0,  100, 1'b1, 1'b0, 2};
    tbl[10] = '{32'd2,  2,  1'b0, 12, 15,  1'b1, 1'b0, 2};
    for (int r = 0; r < 11; r++) begin
      build_image(tbl[r].len, tbl[r].nw, tbl[r].bad);
      gap[tbl[r].stall_at] = tbl[r].stall_len;
      do_reset();
      play(img.size());
      idle(3);
      check($sformatf("row%0d boot_done", r),  boot_done,    tbl[r].exp_done);
      check($sformatf("row%0d boot_error", r), boot_error,   tbl[r].exp_err);
      check($sformatf("row%0d words", r),      words_loaded, tbl[r].exp_words);
      check_vs_model($sformatf("row%0d", r));
    end

    // Reset in the middle of word 3 of an 8-word image, then a full reload.
    build_image(32'd8, 8, 1'b0);
    do_reset();
    for (int i = 0; i < 18; i++) send(img[i]);
    #2 reset = 1'b1;
    #1;
    check("midrst pulses before", pulses,       3);
    check("midrst rx_ready",      rx_ready,     1);
    check("midrst imem_we",       imem_we,      0);
    check("midrst imem_addr",     imem_addr,    0);
    check("midrst imem_wdata",    imem_wdata,   0);
    check("midrst core_reset",    core_reset,   1);
    check("midrst boot_done",     boot_done,    0);
    check("midrst boot_error",    boot_error,   0);
    check("midrst words",         words_loaded, 0);
    rx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    do_reset();
    play(img.size());
    idle(3);
    check_vs_model("reload");

    // Random images, each sent back-to-back and then with random gaps.
    for (int t = 0; t < 8; t++) begin
      n   = $urandom_range(1, DEPTH);
      bad = ($urandom_range(0, 3) == 0);
      build_image(n, n, bad);
      do_reset();
      play(img.size());
      idle(3);
      check_vs_model($sformatf("rnd%0d b2b", t));
      gap[0] = $urandom_range(0, 20);
      for (int i = 1; i < gap.size(); i++)
        gap[i] = ($urandom_range(0, 49) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
      do_reset();
      play(img.size());
      idle(3);
      check_vs_model($sformatf("rnd%0d gap", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/core_boot_loader.md
Name: core_boot_loader

Overview:
Boot sequencer for the single-cycle core. It holds the core in reset while it receives a program image as a byte stream over a valid/ready interface. It writes the image word by word into instruction memory, checks an XOR checksum, and then releases the core. On any load fault the core stays in reset and a sticky error flag is raised.

Parameters:
IMEM_DEPTH, 1024, instruction memory depth in 32-bit words; must be a power of two, >= 2.
TIMEOUT_CYCLES, 100000, maximum idle cycles between accepted bytes once a load has started; 0 disables the timeout.

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-high reset
rx_valid  input  1  byte available on rx_data
rx_data  input  8  stream byte
rx_ready  output  1  loader can accept a byte; a byte transfers when rx_valid && rx_ready at a rising edge
imem_we  output  1  instruction memory write enable, one-cycle pulse per word
imem_addr  output  $clog2(IMEM_DEPTH)  word address of the write
imem_wdata  output  32  word to write
core_reset  output  1  reset to the core; 1 = core held in reset
boot_done  output  1  image loaded and verified; core running
boot_error  output  1  load failed; sticky until reset
words_loaded  output  $clog2(IMEM_DEPTH)+1  count of words written so far

Behaviour:
- Reset (asynchronous, immediate): state=LOAD_LEN, core_reset=1, rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, boot_done=0, boot_error=0, words_loaded=0. Byte index, checksum and timeout counter are cleared.
- Reset asserted mid-load aborts the load. Memory contents already written are not touched. The loader restarts at LOAD_LEN after reset is released.
- Image format, all fields little-endian:
  - 4 bytes: word count N.
  - N x 4 bytes: data words.
  - 1 byte: XOR of all data bytes. The length bytes are not included.
- States:
  - LOAD_LEN: rx_ready=1. Assemble N from 4 bytes. On acceptance of the 4th byte: if N==0 or N>IMEM_DEPTH, go to ERROR; otherwise go to LOAD_DATA.
  - LOAD_DATA: rx_ready=1.
    - Assemble each word; byte 0 is bits [7:0].
    - Each accepted byte updates the running XOR.
    - On the 4th byte of a word, in the next cycle: imem_we=1 for exactly 1 cycle, imem_addr = word index (0, 1, 2, ...), imem_wdata = assembled word, and words_loaded increments in that same cycle.
    - After word N-1 is accepted, go to LOAD_SUM. Byte acceptance continues back-to-back; the write pulse never blocks rx.
  - LOAD_SUM: rx_ready=1. On acceptance: if the byte equals the running XOR, go to RUN; otherwise go to ERROR.
  - RUN: rx_ready=0, core_reset=0, boot_done=1. core_reset falls in the first cycle in RUN, i.e. the cycle after the checksum byte is accepted and after the last imem write pulse. RUN is terminal until reset.
  - ERROR: rx_ready=0, core_reset=1, boot_error=1. ERROR is terminal until reset.
- Timeout:
  - The counter starts after the first length byte is accepted and is cleared on every accepted byte.
  - If it reaches TIMEOUT_CYCLES while in LOAD_LEN (byte index>0), LOAD_DATA or LOAD_SUM, the state goes to ERROR.
  - No timeout applies before the first byte arrives.
- Write addresses never wrap: N<=IMEM_DEPTH is enforced, so the maximum address is IMEM_DEPTH-1 and words_loaded reaches at most IMEM_DEPTH.
- When a byte is accepted in the same cycle the timeout expires, the byte wins: it is processed and no error is raised.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- Outputs are registered. boot_done and boot_error are never 1 simultaneously.

Test Plan:
- Nominal load, N=2:
  - Stimulus: bytes 02 00 00 00, 13 05 10 00, 6F 00 00 00, then checksum 0x69.
  - Required: two imem_we pulses, addr 0 = 0x00100513 and addr 1 = 0x0000006F.
  - Required: core_reset falls the cycle after the checksum byte; boot_done=1; words_loaded=2.
- Bad checksum: same image with checksum 0x00 -> boot_error=1, core_reset stays 1, rx_ready=0, both words still written.
- Illegal length: N=0, then separately N=IMEM_DEPTH+1 -> ERROR after the 4th length byte, no imem_we pulse.
- Timeout: TIMEOUT_CYCLES=16, stall 16 cycles after the 5th byte -> boot_error=1. A stall of 15 cycles followed by continuing -> successful load.
- Back-to-back and gapped: rx_valid held high continuously and also with random gaps -> identical memory contents, one write pulse per word, no dropped bytes.
- Reset mid-load: assert reset during word 3 of N=8 -> all outputs return to reset values immediately. A full reload after release boots normally.
